// File: rtl/data_bus_xbar_pkg.sv
// ----------------------------------------------------------------------------
// data_bus_xbar_pkg
// Shared definitions for the data bus crossbar: FSM state encoding, the LED
// register address and the default RAM / IO / CSR region base/mask pairs that
// integrators use to build REGION_BASE / REGION_MASK.
// No ports (package).
// ----------------------------------------------------------------------------
package data_bus_xbar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } bus_state_e;

  // Address of the LED register when the LED feature is built in.
  localparam logic [63:0] LED_ADDR = 64'h0000_0000_F000_0000;

  // Default region map: RAM 0x1000-0x1FFF, IO 0x1000_0000-0x1000_FFFF,
  // CSR 0x2000_0000-0x2000_00FF.
  localparam logic [63:0] RAM_BASE = 64'h0000_0000_0000_1000;
  localparam logic [63:0] RAM_MASK = ~64'h0000_0000_0000_0FFF;
  localparam logic [63:0] IO_BASE  = 64'h0000_0000_1000_0000;
  localparam logic [63:0] IO_MASK  = ~64'h0000_0000_0000_FFFF;
  localparam logic [63:0] CSR_BASE = 64'h0000_0000_2000_0000;
  localparam logic [63:0] CSR_MASK = ~64'h0000_0000_0000_00FF;

endpackage

// File: rtl/data_bus_decode.sv
// ----------------------------------------------------------------------------
// data_bus_decode
// Combinational address decoder. Region i hits when (addr & mask_i) == base_i;
// when several regions hit, the lowest index wins.
// Ports:
//   addr         in   ADDR_W             address to decode
//   region_base  in   N_TARGETS*ADDR_W   flat base vector, slice i = region i
//   region_mask  in   N_TARGETS*ADDR_W   flat mask vector, slice i = region i
//   hit          out  N_TARGETS          one-hot winning region (0 on miss)
//   miss         out  1                  no region matched
// ----------------------------------------------------------------------------
module data_bus_decode #(
  parameter int N_TARGETS = 3,
  parameter int ADDR_W    = 64
) (
  input  logic [ADDR_W-1:0]           addr,
  input  logic [N_TARGETS*ADDR_W-1:0] region_base,
  input  logic [N_TARGETS*ADDR_W-1:0] region_mask,
  output logic [N_TARGETS-1:0]        hit,
  output logic                        miss
);

  logic [N_TARGETS-1:0] raw_hit;

  genvar gi;
  generate
    for (gi = 0; gi < N_TARGETS; gi++) begin : g_region
      assign raw_hit[gi] =
        ((addr & region_mask[gi*ADDR_W +: ADDR_W]) == region_base[gi*ADDR_W +: ADDR_W]);
    end
  endgenerate

  // Isolate the lowest set bit: x & -x keeps only the lowest-index match.
  assign hit  = raw_hit & (~raw_hit + N_TARGETS'(1));
  assign miss = ~|raw_hit;

endmodule

// File: rtl/data_bus_xbar.sv
// ----------------------------------------------------------------------------
// data_bus_xbar
// Routes one load/store request at a time from the core to one of N_TARGETS
// address regions. Valid/ready on the core side, one-hot strobe held until
// ack on the target side, per-access timeout and decode-miss exception.
// Optional feature macro: DATA_BUS_XBAR_LED_EN (LED register at LED_ADDR).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           core request handshake
//   req_rw/req_addr/req_wdata     request fields (1 = write)
//   resp_valid/resp_ready         core response handshake
//   resp_rdata/resp_exception     response payload
//   tgt_sel                       one-hot target strobe, held until ack
//   tgt_rw/tgt_addr/tgt_wdata     registered request fields to targets
//   tgt_ack/tgt_rdata/tgt_exception  per-target completion, flat read data
//   led                           LED register (0 when feature disabled)
// ----------------------------------------------------------------------------
module data_bus_xbar
  import data_bus_xbar_pkg::*;
#(
  parameter int                              N_TARGETS   = 3,
  parameter int                              ADDR_W      = 64,
  parameter int                              DATA_W      = 64,
  parameter logic [N_TARGETS*ADDR_W-1:0]     REGION_BASE = '0,
  parameter logic [N_TARGETS*ADDR_W-1:0]     REGION_MASK = '0,
  parameter int                              TIMEOUT     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_rw,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [DATA_W-1:0]             req_wdata,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [DATA_W-1:0]             resp_rdata,
  output logic                          resp_exception,
  output logic [N_TARGETS-1:0]          tgt_sel,
  output logic                          tgt_rw,
  output logic [ADDR_W-1:0]             tgt_addr,
  output logic [DATA_W-1:0]             tgt_wdata,
  input  logic [N_TARGETS-1:0]          tgt_ack,
  input  logic [N_TARGETS*DATA_W-1:0]   tgt_rdata,
  input  logic [N_TARGETS-1:0]          tgt_exception,
  output logic [7:0]                    led
);

  // Last counter value spent in ACCESS; ACCESS therefore lasts TIMEOUT cycles.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  bus_state_e            state_q, state_d;
  logic                  rw_q, rw_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [N_TARGETS-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  exc_q, exc_d;
  logic [7:0]            cnt_q, cnt_d;
`ifdef DATA_BUS_XBAR_LED_EN
  logic [7:0]            led_q, led_d;
`endif

  logic [N_TARGETS-1:0]  dec_hit;
  logic                  dec_miss;
  logic                  sel_ack;
  logic                  sel_exc;
  logic [DATA_W-1:0]     sel_rdata;
  logic [DATA_W-1:0]     masked_rdata [N_TARGETS];

  data_bus_decode #(
    .N_TARGETS (N_TARGETS),
    .ADDR_W    (ADDR_W)
  ) u_decode (
    .addr        (req_addr),
    .region_base (REGION_BASE),
    .region_mask (REGION_MASK),
    .hit         (dec_hit),
    .miss        (dec_miss)
  );

  // Only the strobed target may complete the access; acks elsewhere are noise.
  assign sel_ack = |(tgt_ack & sel_q);
  assign sel_exc = |(tgt_exception & sel_q);

  genvar gi;
  generate
    for (gi = 0; gi < N_TARGETS; gi++) begin : g_rdata
      assign masked_rdata[gi] = sel_q[gi] ? tgt_rdata[gi*DATA_W +: DATA_W] : '0;
    end
  endgenerate

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < N_TARGETS; i++) begin
      sel_rdata = sel_rdata | masked_rdata[i];
    end
  end

  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    exc_d   = exc_q;
    cnt_d   = cnt_q;
`ifdef DATA_BUS_XBAR_LED_EN
    led_d   = led_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          rw_d    = req_rw;
          addr_d  = req_addr;
          wdata_d = req_rw ? req_wdata : '0;
          cnt_d   = '0;
`ifdef DATA_BUS_XBAR_LED_EN
          // LED register is intercepted ahead of the region decoder.
          if (req_addr == ADDR_W'(LED_ADDR)) begin
            if (req_rw) begin
              led_d   = req_wdata[7:0];
              rdata_d = '0;
            end else begin
              rdata_d = DATA_W'(led_q);
            end
            exc_d   = 1'b0;
            state_d = ST_RESP;
          end else
`endif
          if (dec_miss) begin
            rdata_d = '0;
            exc_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            sel_d   = dec_hit;
            state_d = ST_ACCESS;
          end
        end
      end

      ST_ACCESS: begin
        // Ack is checked before the timeout so a same-cycle ack completes normally.
        if (sel_ack) begin
          rdata_d = rw_q ? '0 : sel_rdata;
          exc_d   = sel_exc;
          sel_d   = '0;
          cnt_d   = '0;
          state_d = ST_RESP;
        end else if (cnt_q == TIMEOUT_LAST) begin
          rdata_d = '0;
          exc_d   = 1'b1;
          sel_d   = '0;
          cnt_d   = '0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_RESP: begin
        if (resp_ready) begin
          rdata_d = '0;
          exc_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      exc_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef DATA_BUS_XBAR_LED_EN
      led_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      exc_q   <= exc_d;
      cnt_q   <= cnt_d;
`ifdef DATA_BUS_XBAR_LED_EN
      led_q   <= led_d;
`endif
    end
  end

  assign req_ready      = (state_q == ST_IDLE);
  assign resp_valid     = (state_q == ST_RESP);
  assign resp_rdata     = rdata_q;
  assign resp_exception = exc_q;
  assign tgt_sel        = sel_q;
  assign tgt_rw         = rw_q;
  assign tgt_addr       = addr_q;
  assign tgt_wdata      = wdata_q;
`ifdef DATA_BUS_XBAR_LED_EN
  assign led            = led_q;
`else
  assign led            = 8'h00;
`endif

endmodule

// File: tb/tb_data_bus_xbar.sv
module tb_data_bus_xbar;
  import data_bus_xbar_pkg::*;

  localparam int NT = 3;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int TO = 16;

  // Region 2 deliberately overlaps region 1 so lowest-index priority is exercised.
  localparam logic [63:0] R2_BASE = 64'h0000_0000_1000_0000;
  localparam logic [63:0] R2_MASK = ~64'h0000_0000_0FFF_FFFF;
  localparam logic [NT*AW-1:0] BASES = {R2_BASE, IO_BASE, RAM_BASE};
  localparam logic [NT*AW-1:0] MASKS = {R2_MASK, IO_MASK, RAM_MASK};

  typedef struct {
    logic [63:0] rdata;
    logic        exc;
    int          lat;
    int          acc;
    logic [7:0]  led;
  } exp_t;

  typedef struct {
    int          idx;
    logic        rw;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        exc;
    int          d;
    bit          abort;
  } plan_t;

  logic              clk;
  logic              rst;
  logic              req_valid, req_ready, req_rw;
  logic [AW-1:0]     req_addr;
  logic [DW-1:0]     req_wdata;
  logic              resp_valid, resp_ready;
  logic [DW-1:0]     resp_rdata;
  logic              resp_exception;
  logic [NT-1:0]     tgt_sel;
  logic              tgt_rw;
  logic [AW-1:0]     tgt_addr;
  logic [DW-1:0]     tgt_wdata;
  logic [NT-1:0]     tgt_ack;
  logic [NT*DW-1:0]  tgt_rdata;
  logic [NT-1:0]     tgt_exception;
  logic [7:0]        led;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int hold_from = -1;
  int hold_to   = -1;
  logic [7:0] led_m = 8'h00;
  logic [63:0] base_a [NT] = '{RAM_BASE, IO_BASE, R2_BASE};
  logic [63:0] mask_a [NT] = '{RAM_MASK, IO_MASK, R2_MASK};

  exp_t  eq[$];
  plan_t pq[$];

  data_bus_xbar #(
    .N_TARGETS   (NT),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .REGION_BASE (BASES),
    .REGION_MASK (MASKS),
    .TIMEOUT     (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_rw         (req_rw),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_rdata     (resp_rdata),
    .resp_exception (resp_exception),
    .tgt_sel        (tgt_sel),
    .tgt_rw         (tgt_rw),
    .tgt_addr       (tgt_addr),
    .tgt_wdata      (tgt_wdata),
    .tgt_ack        (tgt_ack),
    .tgt_rdata      (tgt_rdata),
    .tgt_exception  (tgt_exception),
    .led            (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference decode: first region whose masked address equals its base.
  function automatic int ref_region(input logic [63:0] a);
    for (int i = 0; i < NT; i++) begin
      if ((a & mask_a[i]) == base_a[i]) return i;
    end
    return -1;
  endfunction

  // Issue one request; caller is just after a rising edge. d = target wait
  // cycles before ack (d >= TO means the target never acks).
  task automatic issue(input logic rw, input logic [63:0] addr, input logic [63:0] wd,
                       input int d, input logic [63:0] trd, input logic texc, input bit abort);
    exp_t  e;
    plan_t p;
    int    region;
    int    waited;
    req_valid = 1'b1;
    req_rw    = rw;
    req_addr  = addr;
    req_wdata = wd;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!req_ready && waited < 300);
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL accept_wait: got req_ready=0 required 1 within 300 cycles");
    end else begin
      region = ref_region(addr);
      e.acc = cyc;
      e.rdata = 64'h0;
      e.exc = 1'b0;
      e.lat = 1;
`ifdef DATA_BUS_XBAR_LED_EN
      if (addr == LED_ADDR) begin
        e.rdata = rw ? 64'h0 : {56'h0, led_m};
        if (rw) led_m = wd[7:0];
        region = -2;
      end
`endif
      if (region == -1) begin
        e.exc = 1'b1;
      end else if (region >= 0) begin
        p.idx = region; p.rw = rw; p.addr = addr; p.wdata = rw ? wd : 64'h0;
        p.rdata = trd; p.exc = texc; p.d = d; p.abort = abort;
        pq.push_back(p);
        if (d >= TO) begin
          e.exc = 1'b1;
          e.lat = TO + 1;
        end else begin
          e.rdata = rw ? 64'h0 : trd;
          e.exc = texc;
          e.lat = d + 2;
        end
      end
      e.led = led_m;
      if (!abort) eq.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_rw    = 1'($urandom);
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'h1);
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'h0);
    chk({tag, "_resp_rdata"}, resp_rdata, 64'h0);
    chk({tag, "_resp_exc"}, 64'(resp_exception), 64'h0);
    chk({tag, "_tgt_sel"}, 64'(tgt_sel), 64'h0);
    chk({tag, "_tgt_rw"}, 64'(tgt_rw), 64'h0);
    chk({tag, "_tgt_addr"}, tgt_addr, 64'h0);
    chk({tag, "_tgt_wdata"}, tgt_wdata, 64'h0);
    chk({tag, "_led"}, 64'(led), 64'h0);
  endtask

  // resp_ready driver: random, forced low inside a requested cycle window.
  initial begin : rr_drv
    resp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (cyc >= hold_from && cyc <= hold_to) resp_ready = 1'b0;
      else resp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Target model: follows the plan queue, adds ack/exception noise elsewhere.
  initial begin : responder
    plan_t cur;
    bit active;
    int k;
    logic [NT-1:0] ack_v, exc_v;
    logic [NT*DW-1:0] rd_v;
    active = 0;
    k = 0;
    tgt_ack = '0;
    tgt_exception = '0;
    tgt_rdata = '0;
    forever begin
      @(negedge clk);
      if (!active && tgt_sel != '0) begin
        if (pq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tgt_sel_unexpected: got %b required 0", tgt_sel);
        end else begin
          cur = pq.pop_front();
          active = 1;
          k = 0;
          chk("tgt_sel_onehot", 64'(tgt_sel), 64'(1 << cur.idx));
          chk("tgt_addr", tgt_addr, cur.addr);
          chk("tgt_rw", 64'(tgt_rw), 64'(cur.rw));
          chk("tgt_wdata", tgt_wdata, cur.wdata);
        end
      end else if (active && tgt_sel == '0) begin
        active = 0;
        if (!cur.abort) chk("tgt_sel_cycles", 64'(k), 64'((cur.d >= TO) ? TO : cur.d + 1));
      end else if (active) begin
        chk("tgt_sel_hold", 64'(tgt_sel), 64'(1 << cur.idx));
      end
      ack_v = NT'($urandom);
      exc_v = NT'($urandom);
      for (int i = 0; i < NT; i++) rd_v[i*DW +: DW] = {$urandom, $urandom};
      if (active) begin
        ack_v[cur.idx] = (k == cur.d);
        if (k == cur.d) begin
          rd_v[cur.idx*DW +: DW] = cur.rdata;
          exc_v[cur.idx] = cur.exc;
        end
        k++;
      end
      tgt_ack = ack_v;
      tgt_exception = exc_v;
      tgt_rdata = rd_v;
    end
  end

  // Response monitor: pops the scoreboard when a response appears.
  initial begin : monitor
    exp_t cur;
    bit in_resp;
    logic [63:0] cap_rd;
    logic cap_exc;
    in_resp = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_resp = 0;
      end else if (resp_valid) begin
        if (!in_resp) begin
          in_resp = 1;
          if (eq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL resp_unexpected: got resp_valid=1 required 0");
          end else begin
            cur = eq.pop_front();
            chk("resp_rdata", resp_rdata, cur.rdata);
            chk("resp_exception", 64'(resp_exception), 64'(cur.exc));
            chk("resp_latency", 64'(cyc - cur.acc), 64'(cur.lat));
            chk("led", 64'(led), 64'(cur.led));
          end
          cap_rd = resp_rdata;
          cap_exc = resp_exception;
        end else begin
          chk("resp_rdata_stable", resp_rdata, cap_rd);
          chk("resp_exc_stable", 64'(resp_exception), 64'(cap_exc));
        end
        chk("req_ready_in_resp", 64'(req_ready), 64'h0);
        if (resp_ready) in_resp = 0;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int r, d, n, waited;
    logic rw;
    logic [63:0] a;
    rst = 1'b1;
    req_valid = 1'b0;
    req_rw = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;

    // Directed cases.
    issue(1'b0, 64'h1008, 64'h0, 2, 64'hDEAD, 1'b0, 0);                 // RAM read, 2 waits
    issue(1'b1, 64'h1000_0010, 64'hA5, 0, 64'h1234, 1'b0, 0);           // IO write, overlap with region 2
    issue(1'b0, 64'hFFFF_0000, 64'h0, 0, 64'h0, 1'b0, 0);               // decode miss
    issue(1'b0, 64'h1800_0040, 64'h0, TO + 10, 64'h5555, 1'b0, 0);      // never acks -> timeout
    issue(1'b0, 64'h1040, 64'h0, TO - 1, 64'hBEEF, 1'b1, 0);            // ack on timeout cycle
    hold_from = cyc;
    hold_to = cyc + 8;
    issue(1'b0, 64'hFFFF_0000, 64'h0, 0, 64'h0, 1'b0, 0);               // response stalled
    repeat (10) @(posedge clk);
    #1;

    // Abort an access with reset: no response, outputs back to reset values.
    issue(1'b0, 64'h1010, 64'h0, 1000, 64'h0, 1'b0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_in_access", 64'(tgt_sel), 64'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    led_m = 8'h00;
    @(negedge clk);
    check_reset_outputs("abort");
    @(posedge clk);
    #1;

`ifdef DATA_BUS_XBAR_LED_EN
    issue(1'b1, LED_ADDR, 64'h3C, 0, 64'h0, 1'b0, 0);
    issue(1'b0, LED_ADDR, 64'h0, 0, 64'h0, 1'b0, 0);
`endif

    // Randomised traffic.
    for (int t = 0; t < 150; t++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: a = 64'h1000 | 64'($urandom_range(0, 32'hFFF));
        3, 4:    a = 64'h1000_0000 | 64'($urandom_range(0, 32'hFFFF));
        5, 6:    a = 64'h1800_0000 | 64'($urandom_range(0, 32'hFF_FFFF));
        7:       a = LED_ADDR;
        default: a = {$urandom, $urandom};
      endcase
      r = $urandom_range(0, 9);
      if (r < 7) d = r % 4;
      else if (r == 7) d = TO - 1;
      else if (r == 8) d = TO;
      else d = 0;
      rw = 1'($urandom);
      issue(rw, a, {$urandom, $urandom}, d, {$urandom, $urandom}, 1'($urandom), 0);
      n = $urandom_range(0, 2);
      repeat (n) begin
        @(posedge clk);
        #1;
      end
    end

    waited = 0;
    while ((eq.size() != 0 || resp_valid) && waited < 500) begin
      @(posedge clk);
      waited++;
    end
    repeat (2) @(negedge clk);
    chk("queues_drained", 64'(eq.size() + pq.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
